data_mem_unit: RTL and testbench

Word-addressed data memory with a wait-state controller, sitting directly downstream of the datapath unit. It takes the ALU result as the address and the register-file read port 2 value as write data, and returns the load result for the write-back mux. A Stall output freezes the core's program counter while an access is outstanding, which lets the single-cycle core run against a memory with a configurable multi-cycle latency.

---
 rtl/data_mem_unit.sv | 151 +++++++++++++++
 tb/tb_data_mem_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// data_mem_unit: word-addressed data memory behind a wait-state controller.
// A request from IDLE latches index/data/op, then spends WAIT_STATES extra
// cycles in WAIT before touching the array. It then spends one cycle in DONE.
// Stall holds the core's PC while the access is outstanding.
//
// Parameters: DEPTH (words, power of two 4..65536), WAIT_STATES (0..15).
// Ports:
//   CLK        rising-edge clock
//   reset      asynchronous active-low reset
//   MemRead    load request
//   MemWrite   store request (wins when both requests are high)
//   Addr       byte address; index = Addr[log2(DEPTH)+1:2], upper bits wrap
//   WriteData  store data
//   ReadData   registered load result, held until the next completed load
//   Stall      combinational: (IDLE & req) | WAIT
//   Done       one-cycle completion pulse (state DONE)
//   AddrErr    misaligned-request flag, valid with Done
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned requests skip the
// access and report AddrErr). When it is undefined, AddrErr is 0 and Addr[1:0]
// is ignored.
module data_mem_unit #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        AddrErr
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               is_store_q, is_store_d;
  logic               err_q, err_d;
  logic [31:0]        read_data_q, read_data_d;
  logic               mem_we;
  logic               req;
  logic               addr_misaligned;
  logic               unused_addr;

  // Not reset: contents survive reset and are undefined at power-up.
  logic [31:0]        mem [DEPTH];

  assign req = MemRead | MemWrite;

`ifdef DMEM_ALIGN_CHECK_EN
  assign addr_misaligned = |Addr[1:0];
  assign unused_addr     = ^Addr[31:IDX_W+2];
`else
  assign addr_misaligned = 1'b0;
  assign unused_addr     = ^{Addr[31:IDX_W+2], Addr[1:0]};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    is_store_d  = is_store_q;
    err_d       = err_q;
    read_data_d = read_data_q;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (addr_misaligned) begin
            // The access is skipped. The request goes straight to DONE with the error flag set.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d      = 1'b0;
            idx_d      = Addr[IDX_W+1:2];
            wdata_d    = WriteData;
            is_store_d = MemWrite;
            cnt_d      = 4'(WAIT_STATES);
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (is_store_q) begin
            mem_we = 1'b1;
          end else begin
            read_data_d = mem[idx_q];
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      is_store_q  <= 1'b0;
      err_q       <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      is_store_q  <= is_store_d;
      err_q       <= err_d;
      read_data_q <= read_data_d;
    end
  end

  // mem_we is only raised from WAIT. Reset forces IDLE, so any store that is
  // still pending when reset arrives is discarded.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ReadData = read_data_q;
  assign Stall    = ((state_q == S_IDLE) && req) || (state_q == S_WAIT);
  assign Done     = (state_q == S_DONE);
  assign AddrErr  = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit (DEPTH=256, WAIT_STATES=2).
// A word-array reference model predicts load data. Each access is checked
// for its Stall length, its Done timing, ReadData and AddrErr.
module tb_data_mem_unit;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WS    = 2;

  logic        CLK;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Done;
  logic        AddrErr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rd;

  data_mem_unit #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Done      (Done),
    .AddrErr   (AddrErr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  // Runs one request. The call starts just after a clock edge with the DUT in IDLE.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
    int unsigned stall_n;
    bit          done_seen;
    MemRead = rd; MemWrite = wr; Addr = a; WriteData = d;
    #1;
    chk({tag, "_stall_req"}, Stall, 1);
    stall_n   = 1;
    done_seen = 0;
    for (int k = 0; k < int'(WS) + 6 && !done_seen; k++) begin
      @(posedge CLK); #1;
      if (k == 0) begin
        // These inputs are latched in IDLE. Changing them afterwards must have no effect.
        MemRead = 1'b0; MemWrite = 1'b0; Addr = $urandom; WriteData = $urandom;
        #1;
      end
      if (Done) done_seen = 1;
      else if (Stall) stall_n++;
    end
    chk({tag, "_done_seen"}, done_seen, 1);
    chk({tag, "_stall_cycles"}, stall_n, WS + 2);
    chk({tag, "_stall_in_done"}, Stall, 0);
    chk({tag, "_addrerr"}, AddrErr, 0);
    if (wr) model_mem[idx_of(a)] = d;
    else if (rd) model_rd = model_mem[idx_of(a)];
    chk({tag, "_rdata"}, ReadData, model_rd);
    // A request presented during DONE must be ignored.
    MemWrite = 1'($urandom_range(0, 1)); MemRead = 1'($urandom_range(0, 1));
    Addr = $urandom; WriteData = $urandom;
    @(posedge CLK); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    chk({tag, "_idle_done"}, Done, 0);
    chk({tag, "_idle_stall"}, Stall, 0);
    chk({tag, "_idle_rdata"}, ReadData, model_rd);
  endtask

  initial begin
    logic [31:0] a;
    logic        rd, wr;
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0;
    model_rd = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rdata", ReadData, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_done", Done, 0);
    chk("rst_addrerr", AddrErr, 0);
    reset = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_stall", Stall, 0);

    // First store, then a load from the same address.
    access("st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access("ld10", 1'b1, 1'b0, 32'h10, 32'h0);
    chk("ld10_value", ReadData, 32'hDEADBEEF);

    // Addresses wrap modulo DEPTH*4, so 0x400 aliases index 0.
    access("st400", 1'b0, 1'b1, 32'h400, 32'h12345678);
    access("ld0", 1'b1, 1'b0, 32'h0, 32'h0);
    chk("wrap_value", ReadData, 32'h12345678);

    // Both requests high is a store.
    access("both20", 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
    chk("both_rdata_kept", ReadData, 32'h12345678);
    access("ld20", 1'b1, 1'b0, 32'h20, 32'h0);
    chk("both_value", ReadData, 32'hA5A5A5A5);

    // Reset in the second WAIT cycle of a store discards that store.
    access("st8_prior", 1'b0, 1'b1, 32'h8, 32'h11111111);
    MemWrite = 1'b1; Addr = 32'h8; WriteData = 32'h55;
    #1;
    chk("rstmid_stall_req", Stall, 1);
    @(posedge CLK); #1;
    MemWrite = 1'b0;
    @(posedge CLK); #1;
    chk("rstmid_stall_wait2", Stall, 1);
    reset = 1'b0;
    #1;
    chk("rstmid_stall_drop", Stall, 0);
    chk("rstmid_rdata", ReadData, 0);
    chk("rstmid_done", Done, 0);
    model_rd = '0;
    @(posedge CLK); #1;
    reset = 1'b1;
    @(posedge CLK); #1;
    chk("rstmid_idle_stall", Stall, 0);
    access("ld8", 1'b1, 1'b0, 32'h8, 32'h0);
    chk("rstmid_kept", ReadData, 32'h11111111);

    // Misaligned store to 0x13, which is index 4.
`ifdef DMEM_ALIGN_CHECK_EN
    MemWrite = 1'b1; Addr = 32'h13; WriteData = 32'hCAFEF00D;
    #1;
    chk("align_stall", Stall, 1);
    @(posedge CLK); #1;
    MemWrite = 1'b0;
    #1;
    chk("align_done", Done, 1);
    chk("align_addrerr", AddrErr, 1);
    chk("align_stall_done", Stall, 0);
    chk("align_rdata", ReadData, model_rd);
    @(posedge CLK); #1;
    chk("align_idle_done", Done, 0);
    chk("align_idle_addrerr", AddrErr, 0);
`else
    access("st13", 1'b0, 1'b1, 32'h13, 32'hCAFEF00D);
`endif
    access("ld10b", 1'b1, 1'b0, 32'h10, 32'h0);
    chk("align_array", ReadData, model_mem[4]);

    // Randomised traffic over indices 0..15, after filling each of them once.
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      a[9:2] = 8'(i);
      a[1:0] = 2'b00;
      access("fill", 1'b0, 1'b1, a, $urandom);
    end
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      a[9:2] = 8'($urandom_range(0, 15));
`ifdef DMEM_ALIGN_CHECK_EN
      a[1:0] = 2'b00;
`endif
      rd = 1'($urandom_range(0, 1));
      wr = ~rd | 1'($urandom_range(0, 1));
      access("rand", rd, wr, a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
